maze_path_rle: RTL and testbench

Downstream consumer of the maze solver's move stream. Accepts one 2-bit direction per valid cycle and tracks the walker's grid position. Compresses the stream into run-length tokens (direction, length) held in a small show-ahead FIFO with a valid/ready output. At end of path it reports the step count, out-of-bounds and overflow errors, and whether the path reached the exit corner.

---
 rtl/maze_path_rle_if.sv | 31 +++
 rtl/maze_path_rle.sv | 187 ++++++++++++++++++
 tb/tb_maze_path_rle.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/maze_path_rle_if.sv
// Move-in / token-out bundle between the maze solver, the run-length encoder and its consumer.
// The slave modport is the encoder's view and the master modport is the driver's view.
interface maze_path_rle_if #(
  parameter int LEN_W  = 5,
  parameter int STEP_W = 9
);
  logic              in_valid;
  logic [1:0]        in_dir;
  logic              tok_valid;
  logic              tok_ready;
  logic [1:0]        tok_dir;
  logic [LEN_W-1:0]  tok_len;
  logic              tok_last;
  logic              done;
  logic              path_ok;
  logic [STEP_W-1:0] total_steps;
  logic              err_oob;
  logic              err_ovf;

  modport master (
    output in_valid, in_dir, tok_ready,
    input  tok_valid, tok_dir, tok_len, tok_last,
    input  done, path_ok, total_steps, err_oob, err_ovf
  );

  modport slave (
    input  in_valid, in_dir, tok_ready,
    output tok_valid, tok_dir, tok_len, tok_last,
    output done, path_ok, total_steps, err_oob, err_ovf
  );
endinterface

// File: rtl/maze_path_rle.sv
// Tracks the walker over a GRIDxGRID maze and run-length encodes its move stream into a
// show-ahead token FIFO, reporting step count, error flags and exit reachability per path.
module maze_path_rle #(
  parameter int GRID       = 17,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 5,
  parameter int STEP_W     = 9
) (
  input logic            clk,
  input logic            rst,
  maze_path_rle_if.slave bus
);
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  localparam int POS_W = $clog2(GRID);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int TOK_W = LEN_W + 3;

  localparam logic [POS_W-1:0]  POS_MAX  = POS_W'(GRID - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX  = '1;
  localparam logic [STEP_W-1:0] STEP_MAX = '1;
  localparam logic [PTR_W-1:0]  PTR_LAST = PTR_W'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FIFO_DEPTH);

  logic [1:0]        state_q,   state_d;
  logic [POS_W-1:0]  row_q,     row_d;
  logic [POS_W-1:0]  col_q,     col_d;
  logic [1:0]        cur_dir_q, cur_dir_d;
  logic [LEN_W-1:0]  len_q,     len_d;
  logic [STEP_W-1:0] steps_q,   steps_d;
  logic              err_oob_q, err_oob_d;
  logic              err_ovf_q, err_ovf_d;
  logic              path_ok_q, path_ok_d;
  logic              done_q,    done_d;

  logic [TOK_W-1:0]  mem_q [FIFO_DEPTH];
  logic [TOK_W-1:0]  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q,  wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q,  rd_ptr_d;
  logic [CNT_W-1:0]  count_q,   count_d;

  logic [POS_W-1:0]  base_row, base_col;
  logic [POS_W-1:0]  mv_row, mv_col;
  logic              mv_oob;
  logic              push, push_ok, pop, full, tok_valid;
  logic [TOK_W-1:0]  push_tok, head;

  assign tok_valid = (count_q != '0);
  assign pop       = tok_valid && bus.tok_ready;
  assign full      = (count_q == CNT_FULL);

  // A fresh path always starts from the origin, regardless of where the last one ended.
  always_comb begin
    base_row = (state_q == S_IDLE) ? '0 : row_q;
    base_col = (state_q == S_IDLE) ? '0 : col_q;
    mv_row   = base_row;
    mv_col   = base_col;
    mv_oob   = 1'b0;
    case (bus.in_dir)
      2'd0: if (base_col == POS_MAX) mv_oob = 1'b1; else mv_col = base_col + POS_W'(1);
      2'd1: if (base_row == POS_MAX) mv_oob = 1'b1; else mv_row = base_row + POS_W'(1);
      2'd2: if (base_col == '0)      mv_oob = 1'b1; else mv_col = base_col - POS_W'(1);
      default: if (base_row == '0)   mv_oob = 1'b1; else mv_row = base_row - POS_W'(1);
    endcase
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    cur_dir_d = cur_dir_q;
    len_d     = len_q;
    steps_d   = steps_q;
    err_oob_d = err_oob_q;
    err_ovf_d = err_ovf_q;
    path_ok_d = path_ok_q;
    done_d    = 1'b0;
    push      = 1'b0;
    push_tok  = '0;
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          state_d   = S_RUN;
          row_d     = mv_row;
          col_d     = mv_col;
          cur_dir_d = bus.in_dir;
          len_d     = LEN_W'(1);
          steps_d   = STEP_W'(1);
          err_oob_d = mv_oob;
          err_ovf_d = 1'b0;
          path_ok_d = 1'b0;
        end
      end
      S_RUN: begin
        if (bus.in_valid) begin
          row_d = mv_row;
          col_d = mv_col;
          if (mv_oob) err_oob_d = 1'b1;
          if (steps_q != STEP_MAX) steps_d = steps_q + STEP_W'(1);
          if (bus.in_dir == cur_dir_q && len_q != LEN_MAX) begin
            len_d = len_q + LEN_W'(1);
          end else begin
            push      = 1'b1;
            push_tok  = {1'b0, cur_dir_q, len_q};
            cur_dir_d = bus.in_dir;
            len_d     = LEN_W'(1);
          end
        end else begin
          push     = 1'b1;
          push_tok = {1'b1, cur_dir_q, len_q};
          state_d  = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (!tok_valid) begin
          done_d    = 1'b1;
          path_ok_d = (row_q == POS_MAX) && (col_q == POS_MAX) && !err_oob_q && !err_ovf_q;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A simultaneous pop frees the slot, so only a push into a full, unpopped FIFO is lost.
    if (push && full && !pop) err_ovf_d = 1'b1;
  end

  always_comb begin
    push_ok  = push && (!full || pop);
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_tok;
      wr_ptr_d        = (wr_ptr_q == PTR_LAST) ? '0 : wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = (rd_ptr_q == PTR_LAST) ? '0 : rd_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push_ok) - CNT_W'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      cur_dir_q <= '0;
      len_q     <= '0;
      steps_q   <= '0;
      err_oob_q <= 1'b0;
      err_ovf_q <= 1'b0;
      path_ok_q <= 1'b0;
      done_q    <= 1'b0;
      mem_q     <= '{default: '0};
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      cur_dir_q <= cur_dir_d;
      len_q     <= len_d;
      steps_q   <= steps_d;
      err_oob_q <= err_oob_d;
      err_ovf_q <= err_ovf_d;
      path_ok_q <= path_ok_d;
      done_q    <= done_d;
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
    end
  end

  assign head            = mem_q[rd_ptr_q];
  assign bus.tok_valid   = tok_valid;
  assign bus.tok_last    = tok_valid & head[TOK_W-1];
  assign bus.tok_dir     = tok_valid ? head[TOK_W-2 -: 2] : 2'd0;
  assign bus.tok_len     = tok_valid ? head[LEN_W-1:0] : '0;
  assign bus.done        = done_q;
  assign bus.path_ok     = path_ok_q;
  assign bus.total_steps = steps_q;
  assign bus.err_oob     = err_oob_q;
  assign bus.err_ovf     = err_ovf_q;
endmodule

// File: tb/tb_maze_path_rle.sv
// Random and directed paths checked against a queue-based token/position reference model.
module tb_maze_path_rle;
  localparam int GRID   = 17;
  localparam int DEPTH  = 4;
  localparam int LEN_W  = 5;
  localparam int STEP_W = 9;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  maze_path_rle_if #(.LEN_W(LEN_W), .STEP_W(STEP_W)) bus ();

  maze_path_rle #(
    .GRID(GRID), .FIFO_DEPTH(DEPTH), .LEN_W(LEN_W), .STEP_W(STEP_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    int dir;
    int len;
    int last;
  } tok_t;

  tok_t model_q[$];
  int   path[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   last_steps, last_oob, last_ovf, last_ok;

  task automatic check_output(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
  endtask

  task automatic append_run(input int dir, input int count);
    for (int i = 0; i < count; i++) path.push_back(dir);
  endtask

  // Drives the current path; hold < 0 gives random tok_ready, otherwise ready rises at cycle hold.
  task automatic run_path(input int ready_pct, input int hold, output int got);
    tok_t sched[$];
    int   sched_edge[$];
    tok_t tmp;
    int   n, cur, run_len, r, c, nr, nc, oob, ovf, sidx, size_before;
    bit   exp_done, flushing, pop, finished;
    n = path.size();
    got = 0;
    cur = path[0];
    run_len = 1;
    for (int j = 1; j < n; j++) begin
      if (path[j] == cur && run_len < 31) run_len++;
      else begin
        sched.push_back('{dir: cur, len: run_len, last: 0});
        sched_edge.push_back(j);
        cur = path[j];
        run_len = 1;
      end
    end
    sched.push_back('{dir: cur, len: run_len, last: 1});
    sched_edge.push_back(n);
    r = 0; c = 0; oob = 0;
    foreach (path[j]) begin
      nr = r; nc = c;
      case (path[j])
        0: nc = c + 1;
        1: nr = r + 1;
        2: nc = c - 1;
        default: nr = r - 1;
      endcase
      if (nr < 0 || nr >= GRID || nc < 0 || nc >= GRID) oob = 1;
      else begin r = nr; c = nc; end
    end
    ovf = 0; sidx = 0; exp_done = 0; flushing = 0; finished = 0;
    for (int e = 0; e <= n + 200 && !finished; e++) begin
      if (e > 0) check_output("done", int'(bus.done), exp_done ? 1 : 0);
      if (exp_done) begin
        last_steps = (n > 511) ? 511 : n;
        last_oob   = oob;
        last_ovf   = ovf;
        last_ok    = (r == GRID - 1 && c == GRID - 1 && oob == 0 && ovf == 0) ? 1 : 0;
        check_output("total_steps", int'(bus.total_steps), last_steps);
        check_output("err_oob", int'(bus.err_oob), last_oob);
        check_output("err_ovf", int'(bus.err_ovf), last_ovf);
        check_output("path_ok", int'(bus.path_ok), last_ok);
        finished = 1;
      end else begin
        check_output("tok_valid", int'(bus.tok_valid), (model_q.size() != 0) ? 1 : 0);
        if (model_q.size() != 0) begin
          check_output("tok_dir", int'(bus.tok_dir), model_q[0].dir);
          check_output("tok_len", int'(bus.tok_len), model_q[0].len);
          check_output("tok_last", int'(bus.tok_last), model_q[0].last);
        end
        if (e < n) begin
          bus.in_valid = 1'b1;
          bus.in_dir   = 2'(path[e]);
        end else if (e == n) begin
          bus.in_valid = 1'b0;
          bus.in_dir   = 2'($urandom_range(0, 3));
        end else begin
          bus.in_valid = 1'($urandom_range(0, 1));
          bus.in_dir   = 2'($urandom_range(0, 3));
        end
        if (hold >= 0) bus.tok_ready = (e >= hold);
        else bus.tok_ready = ($urandom_range(1, 100) <= ready_pct);
        if (bus.tok_valid && bus.tok_ready) got++;
        size_before = model_q.size();
        pop = (size_before != 0) && bus.tok_ready;
        if (pop) tmp = model_q.pop_front();
        exp_done = 0;
        if (flushing && size_before == 0) begin
          exp_done = 1;
          flushing = 0;
        end
        if (sidx < sched.size() && sched_edge[sidx] == e) begin
          if (size_before == DEPTH && !pop) ovf = 1;
          else model_q.push_back(sched[sidx]);
          sidx++;
        end
        if (e == n) flushing = 1;
        @(posedge clk);
        @(negedge clk);
      end
    end
    if (!finished) begin
      check_output("done_timeout", 0, 1);
      model_q.delete();
    end
  endtask

  task automatic idle_gap(input int k);
    for (int i = 0; i < k; i++) begin
      bus.in_valid  = 1'b0;
      bus.in_dir    = 2'($urandom_range(0, 3));
      bus.tok_ready = 1'($urandom_range(0, 1));
      @(posedge clk);
      @(negedge clk);
      check_output("hold_done", int'(bus.done), 0);
      check_output("hold_tok_valid", int'(bus.tok_valid), 0);
      check_output("hold_steps", int'(bus.total_steps), last_steps);
      check_output("hold_oob", int'(bus.err_oob), last_oob);
      check_output("hold_ovf", int'(bus.err_ovf), last_ovf);
      check_output("hold_ok", int'(bus.path_ok), last_ok);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_output({tag, "_tok_valid"}, int'(bus.tok_valid), 0);
    check_output({tag, "_tok_dir"}, int'(bus.tok_dir), 0);
    check_output({tag, "_tok_len"}, int'(bus.tok_len), 0);
    check_output({tag, "_tok_last"}, int'(bus.tok_last), 0);
    check_output({tag, "_done"}, int'(bus.done), 0);
    check_output({tag, "_path_ok"}, int'(bus.path_ok), 0);
    check_output({tag, "_steps"}, int'(bus.total_steps), 0);
    check_output({tag, "_oob"}, int'(bus.err_oob), 0);
    check_output({tag, "_ovf"}, int'(bus.err_ovf), 0);
  endtask

  task automatic apply_stimulus();
    int got, plen, d;
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_dir = 2'd0;
    bus.tok_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    last_steps = 0; last_oob = 0; last_ovf = 0; last_ok = 0;

    path.delete(); append_run(0, 3); append_run(1, 2);
    run_path(100, -1, got);
    check_output("short_tokens", got, 2);
    check_output("short_steps", int'(bus.total_steps), 5);
    check_output("short_ok", int'(bus.path_ok), 0);
    idle_gap(2);

    path.delete(); append_run(0, 16); append_run(1, 16);
    run_path(100, -1, got);
    check_output("full_tokens", got, 2);
    check_output("full_steps", int'(bus.total_steps), 32);
    check_output("full_ok", int'(bus.path_ok), 1);
    idle_gap(1);

    path.delete(); append_run(0, 35);
    run_path(100, -1, got);
    check_output("cap_tokens", got, 2);
    check_output("cap_oob", int'(bus.err_oob), 1);
    check_output("cap_ok", int'(bus.path_ok), 0);
    idle_gap(1);

    path.delete();
    for (int i = 0; i < 6; i++) path.push_back(i % 2);
    run_path(100, 16, got);
    check_output("bp_tokens", got, 4);
    check_output("bp_ovf", int'(bus.err_ovf), 1);
    check_output("bp_ok", int'(bus.path_ok), 0);
    idle_gap(1);

    path.delete();
    for (int i = 0; i < 6; i++) path.push_back(i % 2);
    run_path(100, 5, got);
    check_output("popfull_tokens", got, 6);
    check_output("popfull_ovf", int'(bus.err_ovf), 0);
    idle_gap(1);

    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.in_dir = 2'($urandom_range(0, 3));
      bus.tok_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midreset");
    rst = 1'b0;
    model_q.delete();
    last_steps = 0; last_oob = 0; last_ovf = 0; last_ok = 0;
    idle_gap(3);
    path.delete(); append_run(0, 16); append_run(1, 16);
    run_path(100, -1, got);
    check_output("after_reset_ok", int'(bus.path_ok), 1);
    idle_gap(1);

    for (int p = 0; p < 14; p++) begin
      path.delete();
      plen = $urandom_range(1, 45);
      d = $urandom_range(0, 3);
      for (int i = 0; i < plen; i++) begin
        if ($urandom_range(0, 3) == 0) d = $urandom_range(0, 3);
        path.push_back(d);
      end
      run_path($urandom_range(30, 100), -1, got);
      idle_gap($urandom_range(0, 2));
    end

    path.delete();
    d = 0;
    for (int i = 0; i < 530; i++) begin
      if ($urandom_range(0, 7) == 0) d = $urandom_range(0, 3);
      path.push_back(d);
    end
    run_path(100, -1, got);
    check_output("sat_steps", int'(bus.total_steps), 511);
    idle_gap(1);
  endtask

  initial begin
    apply_stimulus();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
